// File: rtl/var_bus_delay.sv
`default_nettype none
// ============================================================================
// Module      : var_bus_delay
// Description : Programmable-latency bus delay line. Each sample (data plus
//               valid) is written into a circular buffer every cycle and read
//               back dly_cur cycles later. A delay change flushes every stored
//               valid bit and holds the output quiet while the line refills.
// Revision    : 1.0 - initial release
// ============================================================================
module var_bus_delay #(
    parameter int                   BUS_WIDTH = 8,
    parameter int                   MAX_DELAY = 16,
    parameter int                   DLY_W     = 5,
    parameter int                   DEF_DELAY = 3,
    parameter logic [BUS_WIDTH-1:0] INIT_VAL  = {BUS_WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] inbus,
    input  logic                 in_vld,
    input  logic [DLY_W-1:0]     dly_sel,
    input  logic                 dly_load,
    output logic [BUS_WIDTH-1:0] outbus,
    output logic                 out_vld,
    output logic [DLY_W-1:0]     dly_cur,
    output logic                 busy,
    output logic                 dly_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Pointer width; a single-entry buffer still needs a 1-bit pointer.
    localparam int c_PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    // One extra bit so wptr + MAX_DELAY - D never overflows.
    localparam int c_CW    = DLY_W + 1;

    localparam logic [c_CW-1:0]    c_MAX_CW   = c_CW'(MAX_DELAY);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(MAX_DELAY - 1);
    localparam logic [DLY_W-1:0]   c_DEF      = DLY_W'(DEF_DELAY);
    localparam logic [DLY_W-1:0]   c_ONE      = DLY_W'(1);
    localparam logic               c_BUSY_RST = (DEF_DELAY != 0);

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_FILL = 1'b1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [BUS_WIDTH-1:0] r_mem [MAX_DELAY];
    logic [MAX_DELAY-1:0] r_vld;
    logic [c_PTR_W-1:0]   r_wptr;
    logic [0:0]           r_state;
    logic [DLY_W-1:0]     r_fill_cnt;
    logic [DLY_W-1:0]     r_dly_cur;
    logic                 r_busy;
    logic                 r_err;
    logic                 r_rst_d;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                 w_sel_bad;
    logic                 w_load_ok;
    logic                 w_load_bad;
    logic [c_CW-1:0]      w_wp_ext;
    logic [c_CW-1:0]      w_d_ext;
    logic [c_CW-1:0]      w_rd_raw;
    logic [c_PTR_W-1:0]   w_rd_idx;
    logic                 w_buf_vld;
    logic [BUS_WIDTH-1:0] w_buf_dat;
    logic                 w_vld;
    logic [BUS_WIDTH-1:0] w_dat;
    logic [c_CW-c_PTR_W-1:0] w_unused_rd_hi;

    // Requests beyond the buffer depth are rejected, everything else applies.
    assign w_sel_bad  = ({1'b0, dly_sel} > c_MAX_CW);
    assign w_load_ok  = dly_load & ~w_sel_bad;
    assign w_load_bad = dly_load &  w_sel_bad;

    // Read index (wptr - D) mod MAX_DELAY; both operands are < MAX_DELAY+1 so
    // one conditional wrap is enough. D = MAX_DELAY lands on wptr itself and
    // returns the entry before this cycle's write replaces it.
    assign w_wp_ext = c_CW'(r_wptr);
    assign w_d_ext  = {1'b0, r_dly_cur};

    // Modular subtraction for the read pointer.
    always_comb begin
        if (w_wp_ext >= w_d_ext) begin
            w_rd_raw = w_wp_ext - w_d_ext;
        end else begin
            w_rd_raw = w_wp_ext + c_MAX_CW - w_d_ext;
        end
    end

    assign w_rd_idx       = w_rd_raw[c_PTR_W-1:0];
    assign w_unused_rd_hi = w_rd_raw[c_CW-1:c_PTR_W];

    assign w_buf_vld = r_vld[w_rd_idx];
    assign w_buf_dat = r_mem[w_rd_idx];

    // Output select: pass-through at zero delay, buffer otherwise; quiet while
    // filling, during reset and in the cycle right after reset.
    always_comb begin
        w_vld = w_buf_vld;
        w_dat = w_buf_dat;
        if (r_dly_cur == '0) begin
            w_vld = in_vld;
            w_dat = inbus;
        end
        if ((r_state == c_ST_FILL) || rst || r_rst_d) begin
            w_vld = 1'b0;
        end
    end

    assign out_vld = w_vld;
    assign outbus  = w_vld ? w_dat : INIT_VAL;
    assign dly_cur = r_dly_cur;
    assign busy    = rst ? c_BUSY_RST : r_busy;
    assign dly_err = r_err & ~rst;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Write pointer advances every cycle regardless of in_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (r_wptr == c_LAST_PTR) begin
            r_wptr <= '0;
        end else begin
            r_wptr <= r_wptr + c_PTR_W'(1);
        end
    end

    // Valid bits: flushed on reset or accepted load (the sample arriving on
    // that same edge is dropped too), otherwise track in_vld.
    always_ff @(posedge clk) begin
        if (rst || w_load_ok) begin
            r_vld <= '0;
        end else begin
            r_vld[r_wptr] <= in_vld;
        end
    end

    // Data storage needs no reset; a cleared valid bit masks stale content.
    always_ff @(posedge clk) begin
        r_mem[r_wptr] <= inbus;
    end

    // Remember reset for one cycle so the first post-reset cycle stays quiet.
    always_ff @(posedge clk) begin
        r_rst_d <= rst;
    end

    // Delay-control FSM: RUN streams, FILL counts down the refill time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= (DEF_DELAY == 0) ? c_ST_RUN : c_ST_FILL;
            r_fill_cnt <= c_DEF;
            r_busy     <= c_BUSY_RST;
            r_dly_cur  <= c_DEF;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_load_bad;
            if (w_load_ok) begin
                r_dly_cur  <= dly_sel;
                r_fill_cnt <= dly_sel;
                if (dly_sel == '0) begin
                    r_state <= c_ST_RUN;
                    r_busy  <= 1'b0;
                end else begin
                    r_state <= c_ST_FILL;
                    r_busy  <= 1'b1;
                end
            end else if (r_state == c_ST_FILL) begin
                r_fill_cnt <= r_fill_cnt - c_ONE;
                if (r_fill_cnt <= c_ONE) begin
                    r_state <= c_ST_RUN;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_var_bus_delay.sv
`default_nettype none
// ============================================================================
// Module      : tb_var_bus_delay
// Description : Self-checking bench for var_bus_delay. A scoreboard queue
//               holds every valid sample with the cycle it must emerge; a
//               small control model tracks delay, refill count and error.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_var_bus_delay;

    localparam int BW   = 8;
    localparam int MAXD = 16;
    localparam int DW   = 5;
    localparam int DEFD = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] inbus;
    logic          in_vld;
    logic [DW-1:0] dly_sel;
    logic          dly_load;
    logic [BW-1:0] outbus;
    logic          out_vld;
    logic [DW-1:0] dly_cur;
    logic          busy;
    logic          dly_err;

    var_bus_delay #(
        .BUS_WIDTH (BW),
        .MAX_DELAY (MAXD),
        .DLY_W     (DW),
        .DEF_DELAY (DEFD),
        .INIT_VAL  (8'h00)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .inbus    (inbus),
        .in_vld   (in_vld),
        .dly_sel  (dly_sel),
        .dly_load (dly_load),
        .outbus   (outbus),
        .out_vld  (out_vld),
        .dly_cur  (dly_cur),
        .busy     (busy),
        .dly_err  (dly_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [BW-1:0] d;
    } sb_t;

    typedef struct {
        logic [DW-1:0] sel;
        logic          exp_err;
        logic [DW-1:0] exp_cur;
    } vec_t;

    sb_t           sbq[$];
    vec_t          tbl[8];
    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    int            m_d   = DEFD;
    int            m_busy = DEFD;
    logic          m_err = 1'b0;
    logic [BW-1:0] sdat  = 8'h01;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, check at negedge, advance model at posedge.
    task automatic step(input logic r, input logic iv, input logic [BW-1:0] d,
                        input logic ld, input logic [DW-1:0] sel);
        logic          ev;
        logic [BW-1:0] ed;
        rst = r; in_vld = iv; inbus = d; dly_load = ld; dly_sel = sel;
        @(negedge clk);
        ev = 1'b0;
        ed = '0;
        if (r) begin
            chk("busy_in_rst", busy, (DEFD != 0));
            chk("err_in_rst", dly_err, 0);
        end else begin
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL lost_sample cycle %0d: got nothing, want 0x%0h due %0d",
                         cyc, sbq[0].d, sbq[0].due);
                void'(sbq.pop_front());
            end
            if (m_busy > 0) begin
                ev = 1'b0;
            end else if (m_d == 0) begin
                ev = iv;
                ed = iv ? d : '0;
            end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
                ev = 1'b1;
                ed = sbq[0].d;
                void'(sbq.pop_front());
            end
            chk("busy", busy, (m_busy > 0));
            chk("dly_cur", dly_cur, m_d);
            chk("dly_err", dly_err, m_err);
        end
        chk("out_vld", out_vld, ev);
        chk("outbus", outbus, ed);
        @(posedge clk);
        if (r) begin
            sbq.delete();
            m_d = DEFD; m_busy = DEFD; m_err = 1'b0;
        end else if (ld && (int'(sel) <= MAXD)) begin
            sbq.delete();
            m_d = int'(sel); m_busy = int'(sel); m_err = 1'b0;
        end else begin
            m_err = ld;
            if (m_busy > 0) m_busy--;
            if (iv && m_d > 0) sbq.push_back('{cyc + m_d, d});
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, sdat, 1'b0, '0);
            sdat++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h5A, 1'b0, '0);
    endtask

    task automatic ld(input logic [DW-1:0] sel);
        step(1'b0, 1'b1, sdat, 1'b1, sel);
        sdat++;
    endtask

    initial begin
        tbl[0] = '{5'd17, 1'b1, 5'd3};
        tbl[1] = '{5'd31, 1'b1, 5'd3};
        tbl[2] = '{5'd16, 1'b0, 5'd16};
        tbl[3] = '{5'd0,  1'b0, 5'd0};
        tbl[4] = '{5'd1,  1'b0, 5'd1};
        tbl[5] = '{5'd1,  1'b0, 5'd1};
        tbl[6] = '{5'd20, 1'b1, 5'd1};
        tbl[7] = '{5'd5,  1'b0, 5'd5};

        rst = 1'b1; in_vld = 1'b0; inbus = '0; dly_load = 1'b0; dly_sel = '0;
        @(posedge clk);
        #1;

        // Reset held with junk traffic, then a contiguous count stream.
        step(1'b1, 1'b1, 8'hEE, 1'b0, '0);
        step(1'b1, 1'b1, 8'hEF, 1'b1, 5'd9);
        run(30);

        // Load table: each load mid-stream, then let the line settle.
        for (int i = 0; i < 8; i++) begin
            ld(tbl[i].sel);
            chk("tbl_err", dly_err, tbl[i].exp_err);
            chk("tbl_cur", dly_cur, tbl[i].exp_cur);
            run(20);
        end

        // Sparse valid pattern 1,0,0,1 at delay 5 with junk on idle cycles.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, sdat, 1'b0, '0); sdat++;
            step(1'b0, 1'b0, 8'hAA, 1'b0, '0);
            step(1'b0, 1'b0, 8'h55, 1'b0, '0);
            step(1'b0, 1'b1, sdat, 1'b0, '0); sdat++;
        end
        idle(8);

        // Reload during fill restarts it; a bad load during fill is ignored.
        ld(5'd10);
        run(3);
        ld(5'd4);
        run(2);
        ld(5'd25);
        chk("fill_bad_err", dly_err, 1);
        chk("fill_bad_cur", dly_cur, 4);
        run(12);

        // Load held high on consecutive cycles.
        ld(5'd2);
        ld(5'd3);
        ld(5'd4);
        run(10);

        // Reset and load together during fill: reset wins.
        ld(5'd12);
        run(2);
        step(1'b1, 1'b1, sdat, 1'b1, 5'd7);
        chk("rst_win_cur", dly_cur, DEFD);
        run(25);
        idle(20);
        chk("drain_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
